// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//
// Shared types, default constants and the round-robin pick function for the
// FIFO write-side arbiter.
//
// Contents:
//   DEF_*        default parameter values for fifo_wr_arbiter
//   MAX_REQ      widest requester vector the pick function handles (8)
//   arb_state_t  arbiter FSM state (IDLE, BURST)
//   pick_t       result of a round-robin pick: found flag + index
//   rr_pick_fn   rotate-left priority pick starting after a pointer
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 8;
    localparam int DEF_CNT_W     = 16;

    localparam int MAX_REQ = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Search n requesters starting at (ptr + 1) mod n and wrapping upward, so
    // the requester at ptr itself is considered last. ptr must be below n.
    function automatic pick_t rr_pick_fn(
        input logic [MAX_REQ-1:0] req,
        input int                 n,
        input int                 ptr
    );
        pick_t r;
        int    idx;
        r   = '0;
        idx = 0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !r.found) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. Returns the first asserted request found
// searching upward from i_ptr + 1 (mod N); the requester at i_ptr is last.
//
// Ports:
//   i_req    [N-1:0]   request vector
//   i_ptr    [IW-1:0]  round-robin pointer (last winner)
//   o_found            at least one request is asserted
//   o_idx    [IW-1:0]  index of the winning request (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_REQ,
    parameter int IW = $clog2(DEF_NUM_REQ)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [MAX_REQ-1:0] w_req_ext;
    pick_t              w_pick;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = i_req;
    end

    assign w_pick  = rr_pick_fn(w_req_ext, N, int'(i_ptr));
    assign o_found = w_pick.found;
    assign o_idx   = w_pick.idx[IW-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin scheduler for the single write port of the async FIFO. One
// requester at a time holds the grant for a burst of up to MAX_BURST beats;
// accepted beats go straight to write_enable/write_data in the same cycle.
// Runs entirely in the FIFO write clock domain.
//
// Handshake: a beat moves from requester i when req_valid[i] & req_ready[i]
// are both high at a rising edge of w_clk. Requesters keep valid high and data
// stable until their beat is accepted; ready is only ever given to the current
// grant holder, and never while fifo_full or flush is high.
//
// Ports:
//   w_clk         write-domain clock
//   w_rst         asynchronous, active-high reset
//   req_valid     [NUM_REQ]         per-requester beat valid
//   req_data      [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_ready     [NUM_REQ]         per-requester beat accept
//   fifo_full     FIFO full flag
//   flush         flush control; blocks transfers and new grants while high
//   write_enable  FIFO write strobe
//   write_data    [DATA_W]          FIFO write data (0 when not writing)
//   grant_valid   high exactly while the FSM is in BURST (FSM state view)
//   grant_id      [clog2(NUM_REQ)]  index of the granted requester
//   write_count   [CNT_W]           total accepted beats, wraps
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       w_clk,
    input  logic                       w_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    input  logic                       flush,
    output logic                       write_enable,
    output logic [DATA_W-1:0]          write_data,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [CNT_W-1:0]           write_count
);

    localparam int         GW        = $clog2(NUM_REQ);
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    w_grant_id_nxt;
    logic [GW-1:0]    r_rr_ptr;
    logic [GW-1:0]    w_rr_ptr_nxt;
    logic [7:0]       r_beat_cnt;
    logic [7:0]       w_beat_cnt_nxt;
    logic [CNT_W-1:0] r_write_count;

    logic             w_pick_found;
    logic [GW-1:0]    w_pick_idx;
    logic             w_in_burst;
    logic             w_holder_valid;
    logic             w_can_accept;
    logic             w_xfer;
    logic             w_last_beat;
    logic             w_rotate;

    // Single picker shared by the IDLE grant and the BURST-exit re-grant.
    // While in BURST the pointer equals the holder, so the holder is
    // automatically considered last.
    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    assign w_in_burst     = (r_state == BURST);
    assign w_holder_valid = req_valid[r_grant_id];
    assign w_can_accept   = w_in_burst & ~fifo_full & ~flush;
    assign w_xfer         = w_can_accept & w_holder_valid;
    assign w_last_beat    = (r_beat_cnt == LAST_BEAT);

    // Burst ends on the final beat, or when the holder has nothing to send
    // while the FIFO has room. A full FIFO masks the empty-holder case so the
    // grant is kept across back-pressure. Flush is handled separately.
    assign w_rotate = w_in_burst & ~flush &
                      ((w_xfer & w_last_beat) | (~w_holder_valid & ~fifo_full));

    // Output decode
    always_comb begin
        req_ready = '0;
        if (w_can_accept) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign write_enable = w_xfer;
    assign write_data   = w_xfer ? req_data[r_grant_id*DATA_W +: DATA_W] : '0;
    assign grant_valid  = w_in_burst;
    assign grant_id     = r_grant_id;
    assign write_count  = r_write_count;

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;

        case (r_state)
            IDLE: begin
                if (!flush && w_pick_found) begin
                    w_state_nxt    = BURST;
                    w_grant_id_nxt = w_pick_idx;
                    w_rr_ptr_nxt   = w_pick_idx;
                    w_beat_cnt_nxt = 8'd0;
                end
            end

            BURST: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else if (w_rotate) begin
                    // Re-arbitrate in place so back-to-back bursts have no bubble.
                    w_beat_cnt_nxt = 8'd0;
                    if (w_pick_found) begin
                        w_state_nxt    = BURST;
                        w_grant_id_nxt = w_pick_idx;
                        w_rr_ptr_nxt   = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= GW'(NUM_REQ - 1);
            r_beat_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Accepted-beat statistic; free-running wrap.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_write_count <= '0;
        end else if (w_xfer) begin
            r_write_count <= r_write_count + CNT_W'(1);
        end
    end

endmodule
